// File: rtl/vic_vect_prio_pkg.sv
// rtl/vic_vect_prio_pkg.sv - shared levels, widths and reset values for the vectored priority stage
package vic_vect_prio_pkg;

  localparam int NUM_VECT   = 16;
  localparam int DEF_LEVEL  = 16;
  localparam int NONE_LEVEL = 31;
  localparam int NUM_LEVELS = NUM_VECT + 1;
  localparam int LEVEL_W    = 5;

  localparam logic [31:0]        VECT_ADDR_RST = 32'h0000_0000;
  localparam logic [LEVEL_W-1:0] LEVEL_NONE    = LEVEL_W'(NONE_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_DEF     = LEVEL_W'(DEF_LEVEL);

  typedef logic [LEVEL_W-1:0]    level_t;
  typedef logic [NUM_LEVELS-1:0] lvl_vec_t;

endpackage

// File: rtl/vic_prio_enc.sv
// rtl/vic_prio_enc.sv - combinational lowest-eligible-index encoder over request plus in-service mask
module vic_prio_enc
  import vic_vect_prio_pkg::*;
(
  input  lvl_vec_t i_req,
  input  lvl_vec_t i_mask,
  output level_t   o_level,
  output logic     o_valid
);

  logic w_blocked;

  // A level is eligible only if it requests and no level at or above it is in service
  always_comb begin
    o_level   = LEVEL_NONE;
    o_valid   = 1'b0;
    w_blocked = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      w_blocked = w_blocked | i_mask[i];
      if (!o_valid && i_req[i] && !w_blocked) begin
        o_valid = 1'b1;
        o_level = LEVEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/vic_vect_prio.sv
// rtl/vic_vect_prio.sv - vector priority select, in-service nesting and IRQ output; VIC_NESTING_EN enables nesting
module vic_vect_prio
  import vic_vect_prio_pkg::*;
(
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic [15:0]  vIRQRequest,
  input  logic         NonVectIRQ,
  input  logic [511:0] VectAddrFlat,
  input  logic [31:0]  DefVectAddr,
  input  logic         VectAddrRead,
  input  logic         VectAddrWrite,
  output logic [31:0]  VectAddr,
  output logic         nVICIRQ,
  output logic [4:0]   CurLevel,
  output logic [16:0]  InService
);

  lvl_vec_t    r_in_service;
  level_t      r_cur_level;
  logic [31:0] r_vect_addr;
  logic        r_nvicirq;

  lvl_vec_t    w_req;
  lvl_vec_t    w_mask;
  level_t      w_level;
  logic        w_valid;
  logic [31:0] w_addr;
  lvl_vec_t    w_in_service_nxt;

  assign w_req = {NonVectIRQ, vIRQRequest};

`ifdef VIC_NESTING_EN
  assign w_mask = r_in_service;
`else
  // Any level in service blocks every level, so the encoder sees a fully set mask
  assign w_mask = {NUM_LEVELS{|r_in_service}};
`endif

  vic_prio_enc u_enc (
    .i_req   (w_req),
    .i_mask  (w_mask),
    .o_level (w_level),
    .o_valid (w_valid)
  );

  // Address of the winning level; the default level has its own register
  always_comb begin
    w_addr = VectAddrFlat[{w_level[3:0], 5'b00000} +: 32];
    if (w_level == LEVEL_DEF) w_addr = DefVectAddr;
  end

  // EOI clear first, then ack set against the level the CPU currently sees
  always_comb begin
    w_in_service_nxt = r_in_service;
    if (VectAddrWrite) begin
`ifdef VIC_NESTING_EN
      w_in_service_nxt = w_in_service_nxt & (w_in_service_nxt - 17'd1);
`else
      w_in_service_nxt = '0;
`endif
    end
    if (VectAddrRead && (r_cur_level != LEVEL_NONE)) begin
      w_in_service_nxt[r_cur_level] = 1'b1;
    end
  end

  // In-service register and registered IRQ outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_in_service <= '0;
      r_cur_level  <= LEVEL_NONE;
      r_vect_addr  <= VECT_ADDR_RST;
      r_nvicirq    <= 1'b1;
    end else begin
      r_in_service <= w_in_service_nxt;
      r_cur_level  <= w_valid ? w_level : LEVEL_NONE;
      r_nvicirq    <= ~w_valid;
      if (w_valid) r_vect_addr <= w_addr;
    end
  end

  assign VectAddr  = r_vect_addr;
  assign nVICIRQ   = r_nvicirq;
  assign CurLevel  = r_cur_level;
  assign InService = r_in_service;

endmodule

// File: tb/tb_vic_vect_prio.sv
// tb/tb_vic_vect_prio.sv - directed self-checking bench for vic_vect_prio
module tb_vic_vect_prio;

  logic         HCLK;
  logic         HRESETn;
  logic [15:0]  vIRQRequest;
  logic         NonVectIRQ;
  logic [511:0] VectAddrFlat;
  logic [31:0]  DefVectAddr;
  logic         VectAddrRead;
  logic         VectAddrWrite;
  logic [31:0]  VectAddr;
  logic         nVICIRQ;
  logic [4:0]   CurLevel;
  logic [16:0]  InService;

  int n_checks;
  int n_errors;

  vic_vect_prio u_dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .vIRQRequest   (vIRQRequest),
    .NonVectIRQ    (NonVectIRQ),
    .VectAddrFlat  (VectAddrFlat),
    .DefVectAddr   (DefVectAddr),
    .VectAddrRead  (VectAddrRead),
    .VectAddrWrite (VectAddrWrite),
    .VectAddr      (VectAddr),
    .nVICIRQ       (nVICIRQ),
    .CurLevel      (CurLevel),
    .InService     (InService)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ack();
    VectAddrRead = 1'b1;
    tick();
    VectAddrRead = 1'b0;
  endtask

  task automatic eoi();
    VectAddrWrite = 1'b1;
    tick();
    VectAddrWrite = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    HRESETn       = 1'b0;
    vIRQRequest   = 16'h0;
    NonVectIRQ    = 1'b0;
    DefVectAddr   = 32'h0;
    VectAddrRead  = 1'b0;
    VectAddrWrite = 1'b0;
    for (int i = 0; i < 16; i++) VectAddrFlat[32*i +: 32] = 32'(i) << 8;

    tick();
    tick();
    chk("rst_nirq", 32'(nVICIRQ), 32'h1);
    chk("rst_cur", 32'(CurLevel), 32'd31);
    chk("rst_addr", VectAddr, 32'h0);
    chk("rst_insvc", 32'(InService), 32'h0);
    HRESETn = 1'b1;
    tick();
    chk("idle_nirq", 32'(nVICIRQ), 32'h1);

    // single slot
    vIRQRequest = 16'h0020;
    tick();
    chk("slot5_cur", 32'(CurLevel), 32'd5);
    chk("slot5_addr", VectAddr, 32'h0000_0500);
    chk("slot5_nirq", 32'(nVICIRQ), 32'h0);

    // priority between two slots, then drop the winner
    vIRQRequest = 16'h0410;
    tick();
    chk("prio_cur4", 32'(CurLevel), 32'd4);
    vIRQRequest = 16'h0400;
    tick();
    chk("prio_cur10", 32'(CurLevel), 32'd10);
    chk("prio_addr10", VectAddr, 32'h0000_0A00);

    // ack slot 8
    vIRQRequest = 16'h0100;
    tick();
    chk("s8_cur", 32'(CurLevel), 32'd8);
    ack();
    chk("s8_insvc", 32'(InService), 32'h00100);
    tick();
    chk("s8_nirq", 32'(nVICIRQ), 32'h1);
    chk("s8_cur_none", 32'(CurLevel), 32'd31);
    chk("s8_addr_hold", VectAddr, 32'h0000_0800);

`ifdef VIC_NESTING_EN
    // higher priority preempts, gets acked and nests
    vIRQRequest = 16'h0104;
    tick();
    chk("nest_cur2", 32'(CurLevel), 32'd2);
    chk("nest_nirq", 32'(nVICIRQ), 32'h0);
    ack();
    chk("nest_insvc", 32'(InService), 32'h00104);
    vIRQRequest = 16'h0000;
    eoi();
    chk("nest_eoi1", 32'(InService), 32'h00100);
    eoi();
    chk("nest_eoi2", 32'(InService), 32'h00000);
`else
    // without nesting, slot 0 cannot preempt until EOI
    vIRQRequest = 16'h0101;
    tick();
    chk("flat_nirq", 32'(nVICIRQ), 32'h1);
    chk("flat_cur", 32'(CurLevel), 32'd31);
    tick();
    chk("flat_nirq2", 32'(nVICIRQ), 32'h1);
    eoi();
    chk("flat_eoi", 32'(InService), 32'h00000);
    tick();
    chk("flat_cur0", 32'(CurLevel), 32'd0);
    chk("flat_nirq3", 32'(nVICIRQ), 32'h0);
    vIRQRequest = 16'h0000;
`endif
    tick();
    chk("clr_nirq", 32'(nVICIRQ), 32'h1);

    // default (non-vectored) level
    NonVectIRQ  = 1'b1;
    DefVectAddr = 32'hDEF0_0000;
    tick();
    chk("def_cur", 32'(CurLevel), 32'd16);
    chk("def_addr", VectAddr, 32'hDEF0_0000);
    ack();
    chk("def_insvc", 32'(InService), 32'h10000);
    tick();
    chk("def_nirq", 32'(nVICIRQ), 32'h1);
    vIRQRequest = 16'h8000;
    tick();
`ifdef VIC_NESTING_EN
    chk("def_pre_cur", 32'(CurLevel), 32'd15);
    chk("def_pre_addr", VectAddr, 32'h0000_0F00);
`else
    chk("def_pre_cur", 32'(CurLevel), 32'd31);
    chk("def_pre_nirq", 32'(nVICIRQ), 32'h1);
`endif
    vIRQRequest = 16'h0000;
    NonVectIRQ  = 1'b0;
    eoi();
    chk("def_eoi", 32'(InService), 32'h00000);
    tick();

    // simultaneous read and write on the same bit
    vIRQRequest = 16'h0010;
    tick();
    ack();
    chk("rw_insvc_pre", 32'(InService), 32'h00010);
    chk("rw_cur_pre", 32'(CurLevel), 32'd4);
    VectAddrRead  = 1'b1;
    VectAddrWrite = 1'b1;
    tick();
    VectAddrRead  = 1'b0;
    VectAddrWrite = 1'b0;
    chk("rw_insvc", 32'(InService), 32'h00010);
    vIRQRequest = 16'h0000;
    eoi();
    chk("rw_eoi", 32'(InService), 32'h00000);
    eoi();
    chk("eoi_empty", 32'(InService), 32'h00000);

    // async reset while in service
    vIRQRequest = 16'h0008;
    tick();
    ack();
    chk("ar_insvc", 32'(InService), 32'h00008);
    chk("ar_addr_pre", VectAddr, 32'h0000_0300);
    HRESETn = 1'b0;
    #1;
    chk("ar_nirq", 32'(nVICIRQ), 32'h1);
    chk("ar_cur", 32'(CurLevel), 32'd31);
    chk("ar_addr", VectAddr, 32'h0);
    chk("ar_insvc0", 32'(InService), 32'h0);
    tick();
    HRESETn = 1'b1;
    tick();
    chk("ar_rearm", 32'(CurLevel), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
